// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
// Open-drain drive via active-high pull-low enables; line levels read back through 2-FF synchronizers.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_key,
  input  logic       data_key,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       clk_key_oe,
  output logic       data_key_oe,
  output logic       done,
  output logic       err
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     clk_sync_q, data_sync_q;
  logic           clk_prev_q;
  logic [7:0]     data_q, data_d;
  logic           par_q, par_d;
  logic [3:0]     n_q, n_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           err_q, err_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;

  logic clk_s, data_s, fall, timeout;

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_prev_q & ~clk_s;
  assign timeout = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) & ~fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_q      <= '0;
      par_q       <= 1'b0;
      n_q         <= '0;
      icnt_q      <= '0;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], clk_key};
      data_sync_q <= {data_sync_q[0], data_key};
      clk_prev_q  <= clk_s;
      data_q      <= data_d;
      par_q       <= par_d;
      n_q         <= n_d;
      icnt_q      <= icnt_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    n_d       = n_q;
    icnt_d    = icnt_q;
    tcnt_d    = tcnt_q + TCW'(1);
    err_d     = err_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          par_d    = ~^tx_data;
          icnt_d   = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        icnt_d = icnt_q + ICW'(1);
        if (icnt_q == ICW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        n_d       = '0;
        tcnt_d    = '0;
        state_d   = S_SHIFT;
      end

      // Each device falling edge moves the line to the next frame bit.
      S_SHIFT: begin
        if (fall) begin
          tcnt_d = '0;
          n_d    = n_q + 4'd1;
          if (n_q < 4'd8) begin
            data_oe_d = ~data_q[n_q[2:0]];
          end else if (n_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_ACK: begin
        if (fall) begin
          tcnt_d  = '0;
          err_d   = data_s;
          state_d = S_WAIT_IDLE;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = S_DONE;
        end else if (fall) begin
          tcnt_d = '0;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // A dedicated DONE state keeps done and tx_ready mutually exclusive.
  assign tx_ready    = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = done & err_q;
  assign clk_key_oe  = clk_oe_q;
  assign data_key_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx
// Behavioural keyboard model clocks the frame and samples data on rising edges.
module tb_ps2_tx;

  localparam int INH = 10;
  localparam int TMO = 2000;
  localparam int HALF = 40;

  logic       clk;
  logic       rst_n;
  logic       clk_key;
  logic       data_key;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       clk_key_oe;
  logic       data_key_oe;
  logic       done;
  logic       err;

  logic dev_clk_low;
  logic dev_data_low;

  int n_checks;
  int n_fail;
  int overlap;

  assign clk_key  = ~(clk_key_oe | dev_clk_low);
  assign data_key = ~(data_key_oe | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_key    (clk_key),
    .data_key   (data_key),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .clk_key_oe (clk_key_oe),
    .data_key_oe(data_key_oe),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1 && tx_ready === 1'b1) overlap++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit(output int n);
    n = 0;
    while (clk_key_oe === 1'b1 && data_key_oe === 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic run_device(input bit nack, output logic [10:0] seen, output bit req_seen);
    seen = '0;
    req_seen = 1'b0;
    for (int w = 0; w < 200 && !req_seen; w++) begin
      if (clk_key_oe === 1'b0 && data_key_oe === 1'b1) req_seen = 1'b1;
      else tick();
    end
    if (req_seen) begin
      seen[0] = data_key;
      for (int i = 1; i <= 10; i++) begin
        repeat (HALF) tick();
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        seen[i] = data_key;
      end
      repeat (HALF / 2) tick();
      if (!nack) dev_data_low = 1'b1;
      repeat (HALF / 2) tick();
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      if (!nack) begin
        repeat (HALF / 2) tick();
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int bound, output int cycles, output bit got, output logic e,
                           output logic oe_clear);
    cycles = 0;
    while (done !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
    got      = (done === 1'b1);
    e        = err;
    oe_clear = ~clk_key_oe & ~data_key_oe;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({tx_ready, clk_key_oe, data_key_oe, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 10000", {tx_ready, clk_key_oe, data_key_oe, done, err});
    end
    start_send(8'h5A);
    repeat (4) tick();
    n_checks++;
    if (clk_key_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL inhibit_before_reset: clk_key_oe=%b expected 1", clk_key_oe);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({tx_ready, clk_key_oe, data_key_oe, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid_inhibit: got %b expected 10000", {tx_ready, clk_key_oe, data_key_oe, done, err});
    end
    repeat (3) tick();
  endtask

  task automatic test_normal_send();
    int n, cyc;
    bit req, got;
    logic e, clr;
    logic [10:0] seen;
    start_send(8'hED);
    measure_inhibit(n);
    n_checks++;
    if (n !== INH) begin
      n_fail++;
      $display("FAIL inhibit_len: got %0d expected %0d", n, INH);
    end
    n_checks++;
    if ({clk_key_oe, data_key_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL req_lines: got %b expected 11", {clk_key_oe, data_key_oe});
    end
    tick();
    n_checks++;
    if ({clk_key_oe, data_key_oe, tx_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL shift_entry: got %b expected 010", {clk_key_oe, data_key_oe, tx_ready});
    end
    run_device(1'b0, seen, req);
    n_checks++;
    if (seen !== 11'b11_1110_1101_0 || !req) begin
      n_fail++;
      $display("FAIL frame_ED: got %b expected %b", seen, 11'b11_1110_1101_0);
    end
    wait_done(200, cyc, got, e, clr);
    n_checks++;
    if ({got, e, clr} !== 3'b101) begin
      n_fail++;
      $display("FAIL done_ED: got done/err/released %b expected 101", {got, e, clr});
    end
    tick();
    n_checks++;
    if ({tx_ready, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_after_done: got %b expected 10", {tx_ready, done});
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2];
    logic       want_par [2];
    int n, cyc;
    bit req, got;
    logic e, clr;
    logic [10:0] seen;
    vals[0] = 8'h00; want_par[0] = 1'b1;
    vals[1] = 8'h01; want_par[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_send(vals[k]);
      measure_inhibit(n);
      tick();
      run_device(1'b0, seen, req);
      n_checks++;
      if (seen[9] !== want_par[k] || seen !== frame_of(vals[k])) begin
        n_fail++;
        $display("FAIL parity_%02h: got frame %b expected %b", vals[k], seen, frame_of(vals[k]));
      end
      wait_done(200, cyc, got, e, clr);
      tick();
    end
  endtask

  task automatic test_nack();
    int n, cyc;
    bit req, got;
    logic e, clr;
    logic [10:0] seen;
    start_send(8'hFF);
    measure_inhibit(n);
    tick();
    run_device(1'b1, seen, req);
    wait_done(200, cyc, got, e, clr);
    n_checks++;
    if ({got, e, clr} !== 3'b111) begin
      n_fail++;
      $display("FAIL nack: got done/err/released %b expected 111", {got, e, clr});
    end
    tick();
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_ready: tx_ready=%b expected 1", tx_ready);
    end
  endtask

  task automatic test_timeout();
    int n, cyc;
    bit got;
    logic e, clr;
    start_send(8'hF4);
    measure_inhibit(n);
    tick();
    wait_done(TMO + 100, cyc, got, e, clr);
    n_checks++;
    if (cyc !== TMO || {got, e, clr} !== 3'b111) begin
      n_fail++;
      $display("FAIL timeout: got %0d cycles done/err/released %b expected %0d cycles 111", cyc, {got, e, clr}, TMO);
    end
    tick();
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_ready: tx_ready=%b expected 1", tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    bit req, got;
    logic e, clr;
    logic [10:0] seen;
    start_send(8'h3C);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    measure_inhibit(n);
    tick();
    run_device(1'b0, seen, req);
    n_checks++;
    if (seen !== frame_of(8'h3C)) begin
      n_fail++;
      $display("FAIL busy_ignored: got frame %b expected %b", seen, frame_of(8'h3C));
    end
    wait_done(200, cyc, got, e, clr);
    n_checks++;
    if ({got, e} !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_done: got done/err %b expected 10", {got, e});
    end
    tick();
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: tx_ready=%b expected 1", tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if ({clk_key_oe, data_key_oe, tx_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_inhibit: got %b expected 100", {clk_key_oe, data_key_oe, tx_ready});
    end
    measure_inhibit(n);
    tick();
    run_device(1'b0, seen, req);
    n_checks++;
    if (seen !== frame_of(8'hAA)) begin
      n_fail++;
      $display("FAIL b2b_frame: got %b expected %b", seen, frame_of(8'hAA));
    end
    wait_done(200, cyc, got, e, clr);
    tick();
  endtask

  task automatic test_random();
    int n, cyc;
    bit req, got, nack;
    logic e, clr;
    logic [7:0] b;
    logic [10:0] seen;
    for (int k = 0; k < 5; k++) begin
      b    = 8'($urandom);
      nack = 1'($urandom_range(0, 1));
      start_send(b);
      measure_inhibit(n);
      tick();
      run_device(nack, seen, req);
      n_checks++;
      if (seen !== frame_of(b)) begin
        n_fail++;
        $display("FAIL rand_frame_%02h: got %b expected %b", b, seen, frame_of(b));
      end
      wait_done(200, cyc, got, e, clr);
      n_checks++;
      if ({got, e, clr} !== {1'b1, nack, 1'b1}) begin
        n_fail++;
        $display("FAIL rand_done_%02h: got %b expected %b", b, {got, e, clr}, {1'b1, nack, 1'b1});
      end
      tick();
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    overlap      = 0;
    rst_n        = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_normal_send();
    test_parity();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_random();
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL done_ready_overlap: got %0d cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
